// File: rtl/weight_code_gen.sv
// weight_code_gen: streams every N-bit word whose popcount lies in
// [MIN_W, MAX_W], ascending, over a valid/ready handshake. One candidate
// is tested per SEARCH cycle; qualifying words are held in OFFER until taken.
module weight_code_gen #(
  parameter int N     = 4,
  parameter int MIN_W = 2,
  parameter int MAX_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         loop,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic [N:0]   count
);

  typedef enum logic [1:0] {IDLE, SEARCH, OFFER, DONE} state_t;

  localparam logic [N-1:0] LAST = '1;
  localparam logic [N:0]   CMAX = (N+1)'(1) << N;
  localparam logic [3:0]   WMIN = 4'(MIN_W);
  localparam logic [3:0]   WMAX = 4'(MAX_W);

  state_t       state, state_nx;
  logic [N-1:0] cand, cand_nx;
  logic [N:0]   count_nx;
  logic [3:0]   wt;
  logic         qual;

  // popcount of the current candidate (N <= 8 fits in 4 bits)
  always_comb begin
    wt = '0;
    for (int i = 0; i < N; i++) wt = wt + 4'(cand[i]);
  end

  assign qual = (wt >= WMIN) && (wt <= WMAX);

  // next-state, candidate and pass-count logic; abort overrides everything
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    count_nx = count;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nx = SEARCH;
          cand_nx  = '0;
          count_nx = '0;
        end
        SEARCH: begin
          if (qual)              state_nx = OFFER;
          else if (cand == LAST) state_nx = DONE;
          else                   cand_nx  = cand + 1'b1;
        end
        OFFER: if (out_ready) begin
          // saturate rather than wrap
          if (count != CMAX) count_nx = count + (N+1)'(1);
          if (cand == LAST) state_nx = DONE;
          else begin
            state_nx = SEARCH;
            cand_nx  = cand + 1'b1;
          end
        end
        DONE: begin
          if (loop) begin
            state_nx = SEARCH;
            cand_nx  = '0;
            count_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      count <= count_nx;
    end
  end

  // outputs decode straight from registered state, so reset clears them at once
  assign out_valid = (state == OFFER);
  assign out_data  = out_valid ? cand : '0;
  assign busy      = (state == SEARCH) || (state == OFFER);
  assign done      = (state == DONE);

endmodule
